// File: rtl/expr_eval.sv
// Streaming integer expression evaluator: consumes one ASCII character per cycle and
// evaluates "num{*num}{(+|-)term}=" with '*' binding tighter than '+'/'-'.
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   ch,
  output logic [W-1:0] out,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {EXP_NUM, IN_NUM, ERR} state_t;

  typedef enum logic [2:0] {
    ACT_NONE, ACT_DIGIT, ACT_MUL, ACT_ADDSUB, ACT_EQ_OK, ACT_EQ_ERR, ACT_CLEAR, ACT_TO_ERR
  } action_t;

  state_t       state;
  logic [W-1:0] acc, prod, num;
  logic         sign;

  logic [W-1:0] term, total, num_next;
  logic         is_digit;
  action_t      action;

  // The pending term is always prod*num; it is folded into acc with the sign
  // of the operator that preceded it.
  always_comb begin
    term     = prod * num;
    total    = sign ? (acc - term) : (acc + term);
    num_next = (num * W'(10)) + W'(ch[3:0]);
    is_digit = (ch >= "0") && (ch <= "9");
  end

  always_comb begin
    action = ACT_NONE;
    if (in_valid && ch != 8'h20) begin
      if (ch == "C") begin
        action = ACT_CLEAR;
      end else begin
        case (state)
          EXP_NUM: begin
            if (is_digit)        action = ACT_DIGIT;
            else if (ch == "=")  action = ACT_EQ_ERR;
            else                 action = ACT_TO_ERR;
          end
          IN_NUM: begin
            if (is_digit)                     action = ACT_DIGIT;
            else if (ch == "*")               action = ACT_MUL;
            else if (ch == "+" || ch == "-")  action = ACT_ADDSUB;
            else if (ch == "=")               action = ACT_EQ_OK;
            else                              action = ACT_TO_ERR;
          end
          default: begin
            if (ch == "=") action = ACT_EQ_ERR;
          end
        endcase
      end
    end
  end

  // Single state register; terminating and clearing actions all return the
  // evaluator to its start-of-expression values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EXP_NUM;
      acc   <= '0;
      prod  <= W'(1);
      num   <= '0;
      sign  <= 1'b0;
      out   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (action)
        ACT_DIGIT: begin
          num   <= num_next;
          state <= IN_NUM;
        end
        ACT_MUL: begin
          prod  <= term;
          num   <= '0;
          state <= EXP_NUM;
        end
        ACT_ADDSUB: begin
          acc   <= total;
          prod  <= W'(1);
          num   <= '0;
          sign  <= (ch == "-");
          state <= EXP_NUM;
        end
        ACT_EQ_OK, ACT_EQ_ERR, ACT_CLEAR: begin
          if (action == ACT_EQ_OK) begin
            out <= total;
            err <= 1'b0;
            done <= 1'b1;
          end else if (action == ACT_EQ_ERR) begin
            err  <= 1'b1;
            done <= 1'b1;
          end
          state <= EXP_NUM;
          acc   <= '0;
          prod  <= W'(1);
          num   <= '0;
          sign  <= 1'b0;
        end
        ACT_TO_ERR: begin
          state <= ERR;
        end
        default: ;
      endcase
    end
  end

endmodule
